// File: rtl/mac_array_pkg.sv
// mac_array_pkg: shared types and helpers for the multi-lane MAC engine.
//   state_e      - engine control states (IDLE, RUN, FLUSH, DONE)
//   wide_t       - 64-bit scratch type; products and accumulators must fit in it
//   ext_product  - sign- or zero-extends a product of prod_width bits
//   sat_max/min  - saturation limits for an accumulator of w bits
package mac_array_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    localparam int unsigned MAX_W = 64;
    typedef logic [MAX_W-1:0] wide_t;

    // Callers truncate the result to their accumulator width.
    function automatic wide_t ext_product(input wide_t product, input int unsigned prod_width,
                                          input logic is_signed);
        wide_t upper;
        wide_t msb;
        upper = ~wide_t'(0) << prod_width;
        msb   = product >> (prod_width - 1);
        if (is_signed && msb[0]) return product | upper;
        else                     return product & ~upper;
    endfunction

    // Largest representable value: all ones (unsigned) or 0111..1 (signed).
    function automatic wide_t sat_max(input int unsigned w, input logic is_signed);
        wide_t ones;
        ones = ~wide_t'(0) >> (MAX_W - w);
        return is_signed ? (ones >> 1) : ones;
    endfunction

    // Smallest representable value: zero (unsigned) or 1000..0 (signed).
    function automatic wide_t sat_min(input int unsigned w, input logic is_signed);
        return is_signed ? (wide_t'(1) << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/mac_array_lane.sv
// mac_lane: one MAC channel - product register (stage 1) and accumulator (stage 2).
// Optional macro MAC_ARRAY_SAT_EN: saturating accumulation plus a sticky ovf_o flag.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clr_i            abort: clears product, product-valid, accumulator (and ovf_o)
//   start_i          burst start: zeroes the accumulator (and ovf_o)
//   beat_i           an operand beat is accepted this cycle
//   a_i, b_i         operands
//   acc_o            accumulator value
//   ovf_o            sticky saturation flag (MAC_ARRAY_SAT_EN only)
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  start_i,
    input  logic                  beat_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o
`ifdef MAC_ARRAY_SAT_EN
    ,
    output logic                  ovf_o
`endif
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        prod_q, prod_d;
    logic                 prod_valid_q, prod_valid_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
`ifdef MAC_ARRAY_SAT_EN
    logic                 ovf_q, ovf_d;
    logic                 carry;
    logic                 overflow;
    logic [ACC_WIDTH-1:0] limit;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        prod_d       = prod_q;
        prod_valid_d = beat_i;
        acc_d        = acc_q;
        // Operands are widened to PW before multiplying so the full product is kept.
        if (beat_i) begin
            prod_d = (SIGNED != 0) ? PW'(PW'($signed(a_i)) * PW'($signed(b_i)))
                                   : PW'(PW'(a_i) * PW'(b_i));
        end
        prod_ext = ACC_WIDTH'(ext_product(wide_t'(prod_q), PW, SIGNED != 0));
`ifdef MAC_ARRAY_SAT_EN
        ovf_d        = ovf_q;
        {carry, sum} = {1'b0, acc_q} + {1'b0, prod_ext};
        if (SIGNED != 0) begin
            // Signed overflow: both addends share a sign that the sum does not.
            overflow = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
            limit    = acc_q[ACC_WIDTH-1] ? ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1))
                                          : ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b1));
        end else begin
            overflow = carry;
            limit    = ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b0));
        end
        if (prod_valid_q) begin
            acc_d = overflow ? limit : sum;
            ovf_d = ovf_q | overflow;
        end
`else
        sum = acc_q + prod_ext;
        if (prod_valid_q) acc_d = sum;
`endif
        if (clr_i) begin
            prod_d       = '0;
            prod_valid_d = 1'b0;
            acc_d        = '0;
`ifdef MAC_ARRAY_SAT_EN
            ovf_d        = 1'b0;
`endif
        end else if (start_i) begin
            acc_d = '0;
`ifdef MAC_ARRAY_SAT_EN
            ovf_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the datapath registers are reset too, so c_out reads zero straight out of reset.
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
`ifdef MAC_ARRAY_SAT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            acc_q        <= acc_d;
`ifdef MAC_ARRAY_SAT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign acc_o = acc_q;
`ifdef MAC_ARRAY_SAT_EN
    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/mac_array.sv
// mac_array: LANES-wide pipelined multiply-accumulate engine with burst input and
// valid/ready result output. Holds the shared FSM, beat counter and handshakes.
// Optional macro MAC_ARRAY_SAT_EN: saturating lanes plus the ovf output port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr                   synchronous abort back to IDLE
//   start, len            begin a burst of len beats (IDLE only)
//   in_valid, in_ready    operand beat handshake; a_in/b_in carry LANES operands
//   out_valid, out_ready  result handshake; c_out carries LANES accumulators
//   busy                  engine not in IDLE
//   ovf                   per-lane sticky saturation flag (MAC_ARRAY_SAT_EN only)
module mac_array
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int LEN_WIDTH  = 8,
    parameter int SIGNED     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_in,
    input  logic [LANES*DATA_WIDTH-1:0] b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*ACC_WIDTH-1:0]  c_out,
    output logic                        busy
`ifdef MAC_ARRAY_SAT_EN
    ,
    output logic [LANES-1:0]            ovf
`endif
);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 lane_start;

    assign accept     = in_valid && in_ready_q;
    assign lane_start = (state_q == IDLE) && start && !clr;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;   // last product lands in the accumulators
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        // Handshake outputs are registered, decoded from the next state.
        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SIGNED    (SIGNED)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (clr),
            .start_i(lane_start),
            .beat_i (accept),
            .a_i    (a_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .b_i    (b_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .acc_o  (c_out[i*ACC_WIDTH +: ACC_WIDTH])
`ifdef MAC_ARRAY_SAT_EN
            ,
            .ovf_o  (ovf[i])
`endif
        );
    end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: three mac_array instances (unsigned/24-bit, signed/24-bit,
// unsigned/16-bit) share one stimulus stream; results are compared against a
// plain-arithmetic dot-product model of the accepted beats.
module tb_mac_array;

    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int AW_U  = 24;
    localparam int AW_N  = 16;
    localparam int LW    = 8;
`ifdef MAC_ARRAY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst, clr, start, in_valid, out_ready;
    logic [LW-1:0]         len;
    logic [LANES*DW-1:0]   a_in, b_in;

    logic                  in_ready_u, out_valid_u, busy_u;
    logic                  in_ready_s, out_valid_s, busy_s;
    logic                  in_ready_n, out_valid_n, busy_n;
    logic [LANES*AW_U-1:0] c_u, c_s;
    logic [LANES*AW_N-1:0] c_n;
`ifdef MAC_ARRAY_SAT_EN
    logic [LANES-1:0]      ovf_u, ovf_s, ovf_n;
`endif

    logic [LANES*DW-1:0]   plan_a[$], plan_b[$];
    logic [LANES*DW-1:0]   got_a[$], got_b[$];
    int                    n_checks = 0;
    int                    n_fail   = 0;

    always #5 clk = ~clk;

    mac_array #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(AW_U), .LEN_WIDTH(LW), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_u), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid_u), .out_ready(out_ready), .c_out(c_u), .busy(busy_u)
`ifdef MAC_ARRAY_SAT_EN
        , .ovf(ovf_u)
`endif
    );

    mac_array #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(AW_U), .LEN_WIDTH(LW), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_s), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .c_out(c_s), .busy(busy_s)
`ifdef MAC_ARRAY_SAT_EN
        , .ovf(ovf_s)
`endif
    );

    mac_array #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(AW_N), .LEN_WIDTH(LW), .SIGNED(0)) dut_n (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_n), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid_n), .out_ready(out_ready), .c_out(c_n), .busy(busy_n)
`ifdef MAC_ARRAY_SAT_EN
        , .ovf(ovf_n)
`endif
    );

    // Reference: dot product of the accepted beats for one lane, then wrapped
    // modulo 2^acc_w or clamped to the representable range after each beat.
    function automatic logic [63:0] model_lane(input int lane, input int acc_w, input bit sgn,
                                               output bit ovf);
        longint acc, lo, hi, m, av, bv;
        logic [DW-1:0] ab, bb;
        m   = longint'(1) <<< acc_w;
        lo  = sgn ? -(m / 2) : 0;
        hi  = sgn ? (m / 2 - 1) : (m - 1);
        acc = 0;
        ovf = 1'b0;
        foreach (got_a[k]) begin
            ab  = got_a[k][lane*DW +: DW];
            bb  = got_b[k][lane*DW +: DW];
            av  = sgn ? longint'($signed(ab)) : longint'(ab);
            bv  = sgn ? longint'($signed(bb)) : longint'(bb);
            acc = acc + av * bv;
            if (SAT) begin
                if (acc > hi) begin acc = hi; ovf = 1'b1; end
                else if (acc < lo) begin acc = lo; ovf = 1'b1; end
            end else begin
                acc = ((acc % m) + m) % m;
                if (sgn && acc > hi) acc = acc - m;
            end
        end
        return 64'(acc & (m - 1));
    endfunction

    task automatic drive_beat(output bit ok);
        logic [LANES*DW-1:0] a, b;
        a = (plan_a.size() != 0) ? plan_a.pop_front() : LANES*DW'($urandom);
        b = (plan_b.size() != 0) ? plan_b.pop_front() : LANES*DW'($urandom);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (in_ready_u === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        if (ok) begin
            got_a.push_back(a);
            got_b.push_back(b);
        end
        in_valid = 1'b0;
        a_in = LANES*DW'($urandom);
        b_in = LANES*DW'($urandom);
    endtask

    // Runs one burst; lat = clock edges from the final accepted beat (or from
    // start when n == 0) until out_valid is seen, or -1 when aborted in FLUSH.
    task automatic run_burst(input int n, input int min_gap, input int max_gap,
                             input bit abort_in_flush, output int lat);
        bit ok;
        got_a.delete();
        got_b.delete();
        lat   = -1;
        len   = LW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
            drive_beat(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL beat_accept: beat %0d of %0d in_ready=%b, required 1", i, n, in_ready_u);
                return;
            end
        end
        if (abort_in_flush) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            return;
        end
        lat = 1;
        while (out_valid_u !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_output;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks += 4;
        if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL reset out_valid=%b required 0", out_valid_u); end
        if (in_ready_u !== 1'b0)  begin n_fail++; $display("FAIL reset in_ready=%b required 0", in_ready_u); end
        if (busy_u !== 1'b0)      begin n_fail++; $display("FAIL reset busy=%b required 0", busy_u); end
        if (c_u !== '0)           begin n_fail++; $display("FAIL reset c_out=%h required 0", c_u); end
`ifdef MAC_ARRAY_SAT_EN
        n_checks++;
        if (ovf_u !== '0) begin n_fail++; $display("FAIL reset ovf=%b required 0", ovf_u); end
`endif
    endtask

    task automatic test_basic;
        int lat;
        for (int k = 0; k < 3; k++) begin
            plan_a.push_back({24'hFFFFFF, 8'(2 * k + 1)});
            plan_b.push_back({24'hFFFFFF, 8'(2 * k + 2)});
        end
        run_burst(3, 0, 0, 1'b0, lat);
        n_checks += 2;
        if (lat !== 2) begin n_fail++; $display("FAIL basic latency=%0d required 2", lat); end
        if (c_u[AW_U-1:0] !== 24'd44) begin n_fail++; $display("FAIL basic lane0 c_out=%0d required 44", c_u[AW_U-1:0]); end
        for (int l = 1; l < LANES; l++) begin
            n_checks++;
            if (c_u[l*AW_U +: AW_U] !== 24'd195075) begin
                n_fail++;
                $display("FAIL basic lane%0d c_out=%0d required 195075", l, c_u[l*AW_U +: AW_U]);
            end
        end
        release_output();
        n_checks++;
        if (out_valid_u !== 1'b0 || busy_u !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release out_valid=%b busy=%b required 0 0", out_valid_u, busy_u);
        end
    endtask

    task automatic test_stall_backpressure;
        int lat;
        bit eo;
        logic [63:0] e;
        logic [LANES*AW_U-1:0] exp_u, exp_s;
        logic [LANES*AW_N-1:0] exp_n;
        run_burst(5, 1, 3, 1'b0, lat);
        for (int l = 0; l < LANES; l++) begin
            e = model_lane(l, AW_U, 1'b0, eo); exp_u[l*AW_U +: AW_U] = e[AW_U-1:0];
            e = model_lane(l, AW_U, 1'b1, eo); exp_s[l*AW_U +: AW_U] = e[AW_U-1:0];
            e = model_lane(l, AW_N, 1'b0, eo); exp_n[l*AW_N +: AW_N] = e[AW_N-1:0];
        end
        n_checks += 4;
        if (lat !== 2)      begin n_fail++; $display("FAIL stall latency=%0d required 2", lat); end
        if (c_u !== exp_u)  begin n_fail++; $display("FAIL stall unsigned c_out=%h required %h", c_u, exp_u); end
        if (c_s !== exp_s)  begin n_fail++; $display("FAIL stall signed c_out=%h required %h", c_s, exp_s); end
        if (c_n !== exp_n)  begin n_fail++; $display("FAIL stall narrow c_out=%h required %h", c_n, exp_n); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid_u !== 1'b1 || c_u !== exp_u) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d out_valid=%b c_out=%h required 1 %h", c, out_valid_u, c_u, exp_u);
            end
        end
        release_output();
        n_checks += 2;
        if (out_valid_u !== 1'b0 || busy_u !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release out_valid=%b busy=%b required 0 0", out_valid_u, busy_u);
        end
        if (c_u !== exp_u) begin n_fail++; $display("FAIL idle_hold c_out=%h required %h", c_u, exp_u); end
    endtask

    task automatic test_signed;
        int lat;
        bit eo;
        logic [63:0] e;
        logic [31:0] r;
        r = $urandom; plan_a.push_back({r[31:8], 8'h80});
        r = $urandom; plan_b.push_back({r[31:8], 8'h7F});
        r = $urandom; plan_a.push_back({r[31:8], 8'hFF});
        r = $urandom; plan_b.push_back({r[31:8], 8'hFF});
        run_burst(2, 0, 1, 1'b0, lat);
        n_checks += 2;
        if (lat !== 2) begin n_fail++; $display("FAIL signed latency=%0d required 2", lat); end
        if (int'($signed(c_s[AW_U-1:0])) !== -16255) begin
            n_fail++;
            $display("FAIL signed lane0 c_out=%0d required -16255", $signed(c_s[AW_U-1:0]));
        end
        for (int l = 1; l < LANES; l++) begin
            e = model_lane(l, AW_U, 1'b1, eo);
            n_checks++;
            if (c_s[l*AW_U +: AW_U] !== e[AW_U-1:0]) begin
                n_fail++;
                $display("FAIL signed lane%0d c_out=%h required %h", l, c_s[l*AW_U +: AW_U], e[AW_U-1:0]);
            end
        end
        release_output();
    endtask

    task automatic test_len_zero;
        int lat;
        run_burst(0, 0, 0, 1'b0, lat);
        n_checks += 2;
        if (lat !== 1) begin n_fail++; $display("FAIL len0 latency=%0d required 1", lat); end
        if (c_u !== '0 || c_s !== '0 || c_n !== '0) begin
            n_fail++;
            $display("FAIL len0 c_out=%h/%h/%h required 0", c_u, c_s, c_n);
        end
        release_output();
    endtask

    task automatic test_clr_in_flush;
        int lat;
        run_burst(2, 0, 0, 1'b1, lat);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL clr_flush cycle %0d out_valid=%b required 0", c, out_valid_u); end
            @(negedge clk);
        end
        n_checks += 2;
        if (busy_u !== 1'b0) begin n_fail++; $display("FAIL clr_flush busy=%b required 0", busy_u); end
        if (c_u !== '0)      begin n_fail++; $display("FAIL clr_flush c_out=%h required 0", c_u); end
    endtask

    task automatic test_start_with_clr;
        start = 1'b1; clr = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (busy_u !== 1'b0 || in_ready_u !== 1'b0) begin
                n_fail++;
                $display("FAIL start_clr cycle %0d busy=%b in_ready=%b required 0 0", c, busy_u, in_ready_u);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int lat;
        bit eo;
        logic [63:0] e;
        len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) drive_beat(ok);
        n_checks++;
        if (busy_u !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre busy=%b required 1", busy_u); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 2;
        if (busy_u !== 1'b0 || in_ready_u !== 1'b0 || out_valid_u !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b in_ready=%b out_valid=%b required 0 0 0", busy_u, in_ready_u, out_valid_u);
        end
        if (c_u !== '0 || c_n !== '0) begin n_fail++; $display("FAIL rst_mid c_out=%h/%h required 0", c_u, c_n); end
        run_burst(1, 0, 0, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rst_mid len1 latency=%0d required 2", lat); end
        for (int l = 0; l < LANES; l++) begin
            e = model_lane(l, AW_U, 1'b0, eo);
            n_checks++;
            if (c_u[l*AW_U +: AW_U] !== e[AW_U-1:0]) begin
                n_fail++;
                $display("FAIL rst_mid len1 lane%0d c_out=%h required %h", l, c_u[l*AW_U +: AW_U], e[AW_U-1:0]);
            end
        end
        release_output();
    endtask

    task automatic test_overflow;
        int lat;
        bit eo;
        logic [63:0] e;
        for (int n = 2; n <= 3; n++) begin
            repeat (n) begin
                plan_a.push_back({LANES{8'hFF}});
                plan_b.push_back({LANES{8'hFF}});
            end
            run_burst(n, 0, 0, 1'b0, lat);
            for (int l = 0; l < LANES; l++) begin
                e = model_lane(l, AW_N, 1'b0, eo);
                n_checks++;
                if (c_n[l*AW_N +: AW_N] !== e[AW_N-1:0]) begin
                    n_fail++;
                    $display("FAIL ovf len%0d lane%0d c_out=%0d required %0d", n, l, c_n[l*AW_N +: AW_N], e[AW_N-1:0]);
                end
`ifdef MAC_ARRAY_SAT_EN
                n_checks++;
                if (ovf_n[l] !== eo) begin n_fail++; $display("FAIL ovf_flag len%0d lane%0d ovf=%b required %b", n, l, ovf_n[l], eo); end
`endif
            end
            e = model_lane(0, AW_U, 1'b0, eo);
            n_checks++;
            if (c_u[AW_U-1:0] !== e[AW_U-1:0]) begin
                n_fail++;
                $display("FAIL ovf wide len%0d c_out=%0d required %0d", n, c_u[AW_U-1:0], e[AW_U-1:0]);
            end
`ifdef MAC_ARRAY_SAT_EN
            n_checks++;
            if (c_n[AW_N-1:0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat len%0d c_out=%0d required 65535", n, c_n[AW_N-1:0]); end
`else
            if (n == 2) begin
                n_checks++;
                if (c_n[AW_N-1:0] !== 16'd64514) begin n_fail++; $display("FAIL wrap len2 c_out=%0d required 64514", c_n[AW_N-1:0]); end
            end
`endif
            release_output();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_signed();
        test_len_zero();
        test_clr_in_flush();
        test_start_with_clr();
        test_reset_mid_burst();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
